// File: rtl/shift_seq_unit_pkg.sv
// Shared processor package: shift opcodes, sequencer states and step count.
// Used by the ALU control and the iterative shifter.
package shift_seq_unit_pkg;

  localparam logic [3:0] ALU_SLL = 4'b0001;
  localparam logic [3:0] ALU_SRA = 4'b1101;

  localparam int STEPS = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_stage_k.sv
// Single combinational shift stage by a fixed K.
// Left is logical; right is arithmetic.
module shift_stage_k #(
  parameter int K = 1
) (
  input  logic [31:0] dataIn,
  input  logic        right,
  output logic [31:0] dataOut
);

  assign dataOut = right ? 32'($signed(dataIn) >>> K)
                         : dataIn << K;

endmodule

// File: rtl/shift_seq_unit.sv
// Iterative SLL/SRA unit: one binary-weighted stage
// (16, 8, 4, 2, 1) per clock, result pulsed in DONE.
module shift_seq_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_shift,
  input  logic [31:0] data_in,
  input  logic [4:0]  shamt,
  input  logic        right,
  output logic        busy,
  output logic        result_rdy,
  output logic [31:0] result
);
  import shift_seq_unit_pkg::*;

  state_t      state;
  logic [31:0] work;
  logic [4:0]  amt;
  logic        dir;
  logic [2:0]  step;

  logic [31:0] s16, s8, s4, s2, s1;
  logic [31:0] stageOut;
  logic [31:0] nextWork;
  logic        applyBit;
  logic        accept;

  shift_stage_k #(.K(16)) uS16 (
    .dataIn(work), .right(dir), .dataOut(s16));
  shift_stage_k #(.K(8)) uS8 (
    .dataIn(work), .right(dir), .dataOut(s8));
  shift_stage_k #(.K(4)) uS4 (
    .dataIn(work), .right(dir), .dataOut(s4));
  shift_stage_k #(.K(2)) uS2 (
    .dataIn(work), .right(dir), .dataOut(s2));
  shift_stage_k #(.K(1)) uS1 (
    .dataIn(work), .right(dir), .dataOut(s1));

  // Stage k=16>>step is applied when amt[4-step] is set.
  always_comb begin
    stageOut = work;
    applyBit = 1'b0;
    case (step)
      3'd0: begin stageOut = s16; applyBit = amt[4]; end
      3'd1: begin stageOut = s8;  applyBit = amt[3]; end
      3'd2: begin stageOut = s4;  applyBit = amt[2]; end
      3'd3: begin stageOut = s2;  applyBit = amt[1]; end
      3'd4: begin stageOut = s1;  applyBit = amt[0]; end
      default: begin stageOut = work; applyBit = 1'b0; end
    endcase
    nextWork = applyBit ? stageOut : work;
  end

  assign accept = ctrl_shift && (state != RUN);

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      work   <= '0;
      amt    <= '0;
      dir    <= 1'b0;
      step   <= '0;
      result <= '0;
    end else if (accept) begin
      state <= RUN;
      work  <= data_in;
      amt   <= shamt;
      dir   <= right;
      step  <= '0;
    end else begin
      case (state)
        RUN: begin
          work <= nextWork;
          step <= step + 3'd1;
          if (step == 3'(STEPS - 1)) begin
            result <= nextWork;
            state  <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy       = (state == RUN);
  assign result_rdy = (state == DONE);

endmodule

// File: tb/tb_shift_seq_unit.sv
// Randomized self-checking bench for shift_seq_unit.
// Reference: plain shift operators on the requested operands.
module tb_shift_seq_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_shift;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic        right;
  logic        busy;
  logic        result_rdy;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;

  shift_seq_unit dut (
    .clock(clock),
    .reset(reset),
    .ctrl_shift(ctrl_shift),
    .data_in(data_in),
    .shamt(shamt),
    .right(right),
    .busy(busy),
    .result_rdy(result_rdy),
    .result(result)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] refShift(
    input logic [31:0] d, input logic [4:0] s,
    input logic r);
    if (r) return 32'($signed(d) >>> s);
    return d << s;
  endfunction

  // Issue one request, measure latency and busy span, check result.
  task automatic doShift(input string tag, input logic [31:0] d,
                         input logic [4:0] s, input logic r);
    int lat;
    int busyCnt;
    logic [31:0] exp;
    exp = refShift(d, s, r);
    @(negedge clock);
    ctrl_shift = 1'b1;
    data_in = d;
    shamt = s;
    right = r;
    @(negedge clock);
    ctrl_shift = 1'b0;
    data_in = $urandom;
    lat = 0;
    busyCnt = 0;
    for (int i = 1; i <= 20; i++) begin
      if (busy) busyCnt++;
      if (result_rdy) begin
        lat = i;
        break;
      end
      @(negedge clock);
    end
    check({tag, "_lat"}, 32'(lat), 32'd6);
    check({tag, "_busy"}, 32'(busyCnt), 32'd5);
    check({tag, "_res"}, result, exp);
    @(negedge clock);
    check({tag, "_pulse"}, 32'(result_rdy), 32'd0);
    check({tag, "_hold"}, result, exp);
  endtask

  initial begin
    int rdyCnt;
    int t1;
    int t2;
    reset = 1'b1;
    ctrl_shift = 1'b0;
    data_in = '0;
    shamt = '0;
    right = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdy", 32'(result_rdy), 32'd0);
    check("rst_res", result, 32'h0);
    reset = 1'b0;

    doShift("sll31", 32'h0000_0001, 5'd31, 1'b0);
    doShift("sra4n", 32'h8000_0000, 5'd4, 1'b1);
    doShift("sra4p", 32'h7FFF_FFF0, 5'd4, 1'b1);
    doShift("zeroL", 32'hDEAD_BEEF, 5'd0, 1'b0);
    doShift("zeroR", 32'hDEAD_BEEF, 5'd0, 1'b1);

    // Request during RUN is dropped.
    @(negedge clock);
    ctrl_shift = 1'b1;
    data_in = 32'h1;
    shamt = 5'd1;
    right = 1'b0;
    @(negedge clock);
    ctrl_shift = 1'b0;
    @(negedge clock);
    ctrl_shift = 1'b1;
    data_in = 32'h8000_0000;
    shamt = 5'd31;
    right = 1'b1;
    @(negedge clock);
    ctrl_shift = 1'b0;
    rdyCnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (result_rdy) begin
        rdyCnt++;
        check("ign_res", result, 32'h0000_0002);
      end
      @(negedge clock);
    end
    check("ign_cnt", 32'(rdyCnt), 32'd1);

    // Reset mid-RUN discards the shift.
    @(negedge clock);
    ctrl_shift = 1'b1;
    data_in = 32'hFFFF_FFFF;
    shamt = 5'd8;
    right = 1'b0;
    @(negedge clock);
    ctrl_shift = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_res", result, 32'h0);
    rdyCnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (result_rdy) rdyCnt++;
      @(negedge clock);
    end
    check("mid_nordy", 32'(rdyCnt), 32'd0);
    doShift("postrst", 32'hFFFF_FFFF, 5'd8, 1'b0);

    // Back-to-back: request held across DONE.
    @(negedge clock);
    ctrl_shift = 1'b1;
    data_in = 32'h3;
    shamt = 5'd2;
    right = 1'b0;
    t1 = -1;
    t2 = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (result_rdy && t1 < 0) begin
        t1 = i;
        check("b2b_r1", result, 32'h0000_000C);
        data_in = 32'hF000_0000;
        shamt = 5'd16;
        right = 1'b1;
      end else if (result_rdy) begin
        t2 = i;
        check("b2b_r2", result, 32'hFFFF_F000);
        break;
      end else if (t1 >= 0) begin
        ctrl_shift = 1'b0;
      end
    end
    ctrl_shift = 1'b0;
    check("b2b_gap", 32'(t2 - t1), 32'd6);
    check("b2b_seen", 32'(t1 >= 0 && t2 >= 0), 32'd1);

    for (int n = 0; n < 30; n++) begin
      logic [31:0] d;
      logic [4:0] s;
      logic r;
      d = $urandom;
      s = 5'($urandom_range(31, 0));
      r = 1'($urandom_range(1, 0));
      doShift("rnd", d, s, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
